// File: rtl/conv_layer_scheduler.sv
// conv_layer_scheduler: sequences a multi-layer convolution run. For each
// layer it streams WEIGHT_COUNT weight words from an AXI-Stream slave into
// the weight buffer, kicks the compute engine, and waits for completion.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, cfg_num_layers : sequence request and layer count (sampled in IDLE)
//   abort                 : synchronous return to IDLE
//   s_axis_*              : weight stream (tdata/tvalid/tlast in, tready out)
//   weight_wr_*           : weight-buffer write port (one cycle after handshake)
//   conv_start/conv_done  : compute kick pulse / completion pulse
//   layer_idx, busy, done : progress and status
//   err_tlast             : sticky framing error (tlast misplaced)
module conv_layer_scheduler #(
    parameter int unsigned WEIGHT_COUNT = 77,
    parameter int unsigned MAX_LAYERS   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  cfg_num_layers,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [31:0] weight_wr_data,
    output logic [7:0]  weight_wr_addr,
    output logic        weight_wr_en,
    output logic        conv_start,
    input  logic        conv_done,
    output logic [3:0]  layer_idx,
    output logic        busy,
    output logic        done,
    output logic        err_tlast
);

    localparam int unsigned BEAT_W = $clog2(WEIGHT_COUNT + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(WEIGHT_COUNT - 1);
    localparam logic [BEAT_W-1:0] BEAT_LIMIT = BEAT_W'(WEIGHT_COUNT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        KICK   = 3'd2,
        WAIT   = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [3:0]          num_q, num_d;
    logic [3:0]          layer_q, layer_d;
    logic                ready_q, ready_d;
    logic                wr_en_q, wr_en_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic [7:0]          wr_addr_q, wr_addr_d;
    logic                kick_q, kick_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                hs;
    logic                cfg_ok;

    assign hs     = s_axis_tvalid & ready_q;
    assign cfg_ok = (cfg_num_layers != 4'd0) && (32'(cfg_num_layers) <= MAX_LAYERS);

    // State and registered-output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            num_q     <= '0;
            layer_q   <= '0;
            ready_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
            kick_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            num_q     <= num_d;
            layer_q   <= layer_d;
            ready_q   <= ready_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            wr_addr_q <= wr_addr_d;
            kick_q    <= kick_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state and next-output logic; abort overrides everything
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        num_d     = num_q;
        layer_d   = layer_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        wr_addr_d = wr_addr_q;
        err_d     = err_q;

        if (abort) begin
            state_d = IDLE;
            beat_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        err_d = 1'b0;
                        if (cfg_ok) begin
                            state_d = LOAD;
                            num_d   = cfg_num_layers;
                            layer_d = '0;
                            beat_d  = '0;
                        end else begin
                            state_d = FINISH;
                        end
                    end
                end
                LOAD: begin
                    if (hs) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = s_axis_tdata;
                        wr_addr_d = 8'(beat_q);
                        beat_d    = beat_q + BEAT_W'(1);
                        // tlast must appear on the final beat and nowhere else
                        if (s_axis_tlast != (beat_q == LAST_BEAT)) begin
                            err_d = 1'b1;
                        end
                        if (beat_q == LAST_BEAT) begin
                            state_d = KICK;
                        end
                    end
                end
                KICK: begin
                    state_d = WAIT;
                end
                WAIT: begin
                    if (conv_done) begin
                        if (layer_q == num_q - 4'd1) begin
                            state_d = FINISH;
                        end else begin
                            state_d = LOAD;
                            layer_d = layer_q + 4'd1;
                            beat_d  = '0;
                        end
                    end
                end
                FINISH: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Status outputs are registered views of the upcoming state
        ready_d = (state_d == LOAD) && (beat_d < BEAT_LIMIT);
        kick_d  = (state_d == KICK);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == FINISH);
    end

    assign s_axis_tready  = ready_q;
    assign weight_wr_en   = wr_en_q;
    assign weight_wr_data = wr_data_q;
    assign weight_wr_addr = wr_addr_q;
    assign conv_start     = kick_q;
    assign layer_idx      = layer_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_tlast      = err_q;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Scoreboard bench for conv_layer_scheduler: stimulus pushes expected weight
// writes, kicks and done pulses into queues; a negedge monitor pops and
// compares whenever the DUT presents one.
module tb_conv_layer_scheduler;

    localparam int WC = 77;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [3:0]  cfg_num_layers;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [31:0] weight_wr_data;
    logic [7:0]  weight_wr_addr;
    logic        weight_wr_en;
    logic        conv_start;
    logic        conv_done;
    logic [3:0]  layer_idx;
    logic        busy;
    logic        done;
    logic        err_tlast;

    conv_layer_scheduler #(.WEIGHT_COUNT(WC), .MAX_LAYERS(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .cfg_num_layers (cfg_num_layers),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tready  (s_axis_tready),
        .weight_wr_data (weight_wr_data),
        .weight_wr_addr (weight_wr_addr),
        .weight_wr_en   (weight_wr_en),
        .conv_start     (conv_start),
        .conv_done      (conv_done),
        .layer_idx      (layer_idx),
        .busy           (busy),
        .done           (done),
        .err_tlast      (err_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [3:0] exp_kick[$];
    logic [4:0] exp_done[$];   // {err_tlast, layer_idx}

    int checks = 0;
    int errors = 0;
    int wr_seen = 0;
    int kick_seen = 0;
    int done_seen = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every DUT event must match the head of its expectation queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (weight_wr_en) begin
                wr_seen++;
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", {24'd0, weight_wr_addr}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", 32'(weight_wr_addr), 32'(e.addr));
                    chk("wr_data", weight_wr_data, e.data);
                end
            end
            if (conv_start) begin
                kick_seen++;
                if (exp_kick.size() == 0) begin
                    chk("kick_unexpected", 32'(layer_idx), 32'hFFFF_FFFF);
                end else begin
                    chk("kick_layer", 32'(layer_idx), 32'(exp_kick.pop_front()));
                end
            end
            if (done) begin
                done_seen++;
                if (exp_done.size() == 0) begin
                    chk("done_unexpected", 32'(layer_idx), 32'hFFFF_FFFF);
                end else begin
                    logic [4:0] d;
                    d = exp_done.pop_front();
                    chk("done_layer", 32'(layer_idx), 32'(d[3:0]));
                    chk("done_err", 32'(err_tlast), 32'(d[4]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] n);
        start = 1'b1;
        cfg_num_layers = n;
        step();
        start = 1'b0;
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic last, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        while (n < 50) begin
            if (s_axis_tready) begin
                step();
                ok = 1'b1;
                break;
            end
            step();
            n++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // One full layer: 77 beats, then junk held on the stream through KICK/WAIT
    task automatic run_layer(input int tag, input int layer, input bit gaps, input int bad_beat,
                             input int cd_beat, input bit start_in_wait, input bit send_done);
        bit ok;
        int n;
        int k0;
        logic [31:0] d;
        logic last;
        k0 = kick_seen;
        for (int b = 0; b < WC; b++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                repeat ($urandom_range(1, 3)) step();
            end
            d = {8'hD0, 8'(tag), 8'(layer), 8'(b)};
            last = (b == WC - 1);
            if (b == bad_beat) last = ~last;
            conv_done = (b == cd_beat);
            exp_wr.push_back({8'(b), d});
            drive_beat(d, last, ok);
            conv_done = 1'b0;
            if (!ok) begin
                chk("beat_timeout", 32'(b), 32'hFFFF_FFFF);
                return;
            end
        end
        exp_kick.push_back(4'(layer));
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hDEAD_BEEF;
        s_axis_tlast  = 1'b1;
        n = 0;
        while (kick_seen == k0 && n < 20) begin
            step();
            n++;
        end
        chk("kick_count", 32'(kick_seen - k0), 32'd1);
        repeat (3) step();
        chk("tready_after_load", 32'(s_axis_tready), 32'd0);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (start_in_wait) begin
            do_start(4'd1);
        end
        if (send_done) begin
            conv_done = 1'b1;
            step();
            conv_done = 1'b0;
        end
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_seen == d0 && n < 20) begin
            step();
            n++;
        end
        chk("done_count", 32'(done_seen - d0), 32'd1);
        step();
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_wr_left"},   32'(exp_wr.size()),   32'd0);
        chk({tag, "_kick_left"}, 32'(exp_kick.size()), 32'd0);
        chk({tag, "_done_left"}, 32'(exp_done.size()), 32'd0);
    endtask

    initial begin
        int d0;
        int w0;
        int k0;
        bit ok;
        logic [31:0] d;

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cfg_num_layers = 4'd0;
        s_axis_tdata = 32'd0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        conv_done = 1'b0;
        repeat (3) step();

        chk("rst_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_wr_en", 32'(weight_wr_en), 32'd0);
        chk("rst_wr_data", weight_wr_data, 32'd0);
        chk("rst_wr_addr", 32'(weight_wr_addr), 32'd0);
        chk("rst_conv_start", 32'(conv_start), 32'd0);
        chk("rst_layer", 32'(layer_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_tlast), 32'd0);
        rst_n = 1'b1;
        step();

        // Single layer, continuous stream
        d0 = done_seen;
        exp_done.push_back({1'b0, 4'd0});
        do_start(4'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_tready", 32'(s_axis_tready), 32'd1);
        run_layer(1, 0, 1'b0, -1, -1, 1'b0, 1'b1);
        wait_done(d0);
        chk("t1_err", 32'(err_tlast), 32'd0);
        check_drained("t1");

        // Three layers with random tvalid gaps
        d0 = done_seen;
        w0 = wr_seen;
        k0 = kick_seen;
        exp_done.push_back({1'b0, 4'd2});
        do_start(4'd3);
        for (int l = 0; l < 3; l++) begin
            run_layer(2, l, 1'b1, -1, -1, 1'b0, 1'b1);
        end
        wait_done(d0);
        chk("t2_writes", 32'(wr_seen - w0), 32'd231);
        chk("t2_kicks", 32'(kick_seen - k0), 32'd3);
        chk("t2_layer_hold", 32'(layer_idx), 32'd2);
        check_drained("t2");

        // Early tlast on beat 10
        d0 = done_seen;
        w0 = wr_seen;
        exp_done.push_back({1'b1, 4'd0});
        do_start(4'd1);
        run_layer(3, 0, 1'b0, 10, -1, 1'b0, 1'b1);
        wait_done(d0);
        chk("t3a_writes", 32'(wr_seen - w0), 32'd77);
        chk("t3a_err_sticky", 32'(err_tlast), 32'd1);

        // Missing tlast on beat 76; new start clears the flag first
        d0 = done_seen;
        exp_done.push_back({1'b1, 4'd0});
        do_start(4'd1);
        chk("t3b_err_cleared", 32'(err_tlast), 32'd0);
        run_layer(4, 0, 1'b0, WC - 1, -1, 1'b0, 1'b1);
        wait_done(d0);
        chk("t3b_err", 32'(err_tlast), 32'd1);
        check_drained("t3");

        // Zero and over-range layer counts go straight to FINISH
        w0 = wr_seen;
        for (int i = 0; i < 2; i++) begin
            d0 = done_seen;
            exp_done.push_back({1'b0, 4'd0});
            do_start((i == 0) ? 4'd0 : 4'd9);
            chk("t4_busy", 32'(busy), 32'd1);
            chk("t4_done", 32'(done), 32'd1);
            chk("t4_tready", 32'(s_axis_tready), 32'd0);
            step();
            chk("t4_busy_end", 32'(busy), 32'd0);
            chk("t4_done_end", 32'(done), 32'd0);
            chk("t4_tready_end", 32'(s_axis_tready), 32'd0);
            chk("t4_done_count", 32'(done_seen - d0), 32'd1);
        end
        chk("t4_writes", 32'(wr_seen - w0), 32'd0);
        check_drained("t4");

        // Abort on beat 40 (beat 5 carries a stray tlast so err must hold)
        d0 = done_seen;
        do_start(4'd2);
        for (int b = 0; b < 40; b++) begin
            d = {8'hD0, 8'd5, 8'd0, 8'(b)};
            exp_wr.push_back({8'(b), d});
            drive_beat(d, (b == 5), ok);
            if (!ok) chk("t5_beat_timeout", 32'(b), 32'hFFFF_FFFF);
        end
        chk("t5_tready_pre", 32'(s_axis_tready), 32'd1);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hBAD0_0040;
        start = 1'b1;
        cfg_num_layers = 4'd1;
        abort = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        s_axis_tvalid = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_tready", 32'(s_axis_tready), 32'd0);
        chk("t5_wr_en", 32'(weight_wr_en), 32'd0);
        chk("t5_conv_start", 32'(conv_start), 32'd0);
        chk("t5_err_hold", 32'(err_tlast), 32'd1);
        chk("t5_layer_hold", 32'(layer_idx), 32'd0);
        repeat (3) step();
        chk("t5_no_done", 32'(done_seen - d0), 32'd0);
        exp_done.push_back({1'b0, 4'd0});
        do_start(4'd1);
        run_layer(6, 0, 1'b0, -1, -1, 1'b0, 1'b1);
        wait_done(d0);
        check_drained("t5");

        // Asynchronous reset while waiting on layer 1
        d0 = done_seen;
        do_start(4'd2);
        run_layer(7, 0, 1'b0, -1, -1, 1'b0, 1'b1);
        run_layer(7, 1, 1'b0, 20, -1, 1'b0, 1'b0);
        chk("t6_layer_pre", 32'(layer_idx), 32'd1);
        chk("t6_err_pre", 32'(err_tlast), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_layer", 32'(layer_idx), 32'd0);
        chk("t6_err", 32'(err_tlast), 32'd0);
        chk("t6_wr_addr", 32'(weight_wr_addr), 32'd0);
        chk("t6_wr_data", weight_wr_data, 32'd0);
        chk("t6_tready", 32'(s_axis_tready), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("t6_no_done", 32'(done_seen - d0), 32'd0);
        exp_done.push_back({1'b0, 4'd0});
        do_start(4'd1);
        run_layer(8, 0, 1'b0, -1, -1, 1'b0, 1'b1);
        wait_done(d0);
        check_drained("t6");

        // conv_done during LOAD and start during WAIT are both ignored
        d0 = done_seen;
        k0 = kick_seen;
        exp_done.push_back({1'b0, 4'd1});
        do_start(4'd2);
        run_layer(9, 0, 1'b0, -1, 30, 1'b0, 1'b1);
        run_layer(9, 1, 1'b0, -1, -1, 1'b1, 1'b1);
        wait_done(d0);
        chk("t7_kicks", 32'(kick_seen - k0), 32'd2);
        chk("t7_layer_hold", 32'(layer_idx), 32'd1);
        check_drained("t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
